// File: rtl/intr_gen.sv
// intr_gen: interrupt generator between the register bank and the block's
// interrupt line.
//
// It holds the raw interrupt status (sticky, W1C, init-clear) and applies the
// mask, with NON_MASKABLE bits bypassing it. It then drives o_intr in one of
// two modes:
//   level (i_trig_type=0): registered OR of the masked status.
//   pulse (i_trig_type=1): a pulse of max(i_pulse_width,1) cycles on every
//                          rising edge of any masked status bit. Pulses are
//                          separated by at least one low cycle.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_intr_src[INTR_NUM]    per-source event strobes
//   i_msk[INTR_NUM]         mask, 1 = masked
//   i_clr_vld, i_clr        write-1-to-clear strobe and data
//   i_init_clr              init-clear strobe (acts on INIT_CLR bits)
//   i_trig_type             0 = level, 1 = pulse
//   i_pulse_width           pulse length in cycles (0 behaves as 1)
//   o_raw_stat              raw status register
//   o_intr_stat             masked status (combinational)
//   o_intr                  registered interrupt line
module intr_gen #(
  parameter int                  INTR_NUM       = 2,
  parameter int                  PULSE_WIDTH_BW = 8,
  parameter logic [INTR_NUM-1:0] NON_MASKABLE   = 'b01,
  parameter logic [INTR_NUM-1:0] INIT_CLR       = 'b01
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [INTR_NUM-1:0]       i_intr_src,
  input  logic [INTR_NUM-1:0]       i_msk,
  input  logic                      i_clr_vld,
  input  logic [INTR_NUM-1:0]       i_clr,
  input  logic                      i_init_clr,
  input  logic                      i_trig_type,
  input  logic [PULSE_WIDTH_BW-1:0] i_pulse_width,
  output logic [INTR_NUM-1:0]       o_raw_stat,
  output logic [INTR_NUM-1:0]       o_intr_stat,
  output logic                      o_intr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [PULSE_WIDTH_BW-1:0] CNT_ONE = PULSE_WIDTH_BW'(1);

  logic [INTR_NUM-1:0]       raw_q, raw_d;
  logic [INTR_NUM-1:0]       stat_q, stat_d;
  logic [INTR_NUM-1:0]       clr_eff;
  logic [INTR_NUM-1:0]       intr_stat;
  logic                      trig_type_q, trig_type_d;
  logic                      intr_q, intr_d;
  logic                      pend_q, pend_d;
  logic [PULSE_WIDTH_BW-1:0] cnt_q, cnt_d;
  logic [PULSE_WIDTH_BW-1:0] cnt_load;
  state_t                    state_q, state_d;
  logic                      trig;
  logic                      type_chg;

  // Raw status: a set in the same cycle as a clear wins because the source
  // term is OR-ed in after the clear is applied.
  always_comb begin
    clr_eff = (i_clr_vld ? i_clr : '0) | (i_init_clr ? INIT_CLR : '0);
    raw_d   = i_intr_src | (raw_q & ~clr_eff);
  end

  assign intr_stat = raw_q & (~i_msk | NON_MASKABLE);

  // A trigger is any masked-status bit rising. An unmask of a pending bit
  // appears here as a rise too, so it needs no separate term.
  always_comb begin
    stat_d      = intr_stat;
    trig_type_d = i_trig_type;
    trig        = |(intr_stat & ~stat_q);
    type_chg    = i_trig_type ^ trig_type_q;
    cnt_load    = (i_pulse_width == '0) ? '0 : (i_pulse_width - CNT_ONE);
  end

  // Pulse FSM. While in level mode it is held idle. A mode change forces it
  // idle so the new mode starts from a clean state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (type_chg || !i_trig_type) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig) begin
            state_d = ST_PULSE;
            cnt_d   = cnt_load;
          end
        end
        ST_PULSE: begin
          // Triggers during a pulse are remembered, not used to stretch it.
          if (trig) begin
            pend_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (pend_q || trig) begin
            pend_d  = 1'b0;
            cnt_d   = cnt_load;
            state_d = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // The line is registered in both modes. In pulse mode it reflects the state
  // being entered, so it goes high the cycle after the trigger.
  always_comb begin
    if (i_trig_type) begin
      intr_d = (state_d == ST_PULSE);
    end else begin
      intr_d = |intr_stat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      raw_q       <= '0;
      stat_q      <= '0;
      trig_type_q <= 1'b0;
      intr_q      <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
    end else begin
      raw_q       <= raw_d;
      stat_q      <= stat_d;
      trig_type_q <= trig_type_d;
      intr_q      <= intr_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  assign o_raw_stat  = raw_q;
  assign o_intr_stat = intr_stat;
  assign o_intr      = intr_q;

endmodule

// File: tb/tb_intr_gen.sv
// Testbench for intr_gen: directed scenarios followed by randomized traffic,
// checked against a cycle-level behavioural model of the interrupt line.
module tb_intr_gen;

  localparam logic [1:0] NM = 2'b01;
  localparam logic [1:0] IC = 2'b01;

  logic       clk;
  logic       rst_n;
  logic [1:0] src, msk, clr;
  logic       clr_vld, init_clr, trig_type;
  logic [7:0] pw;
  logic [1:0] raw_stat, intr_stat;
  logic       intr;

  int checks;
  int errors;

  // Behavioural model state
  logic [1:0] m_raw, m_prev;
  logic       m_type, m_intr, m_active, m_gap, m_pend;
  int         m_left;

  intr_gen #(
    .INTR_NUM      (2),
    .PULSE_WIDTH_BW(8),
    .NON_MASKABLE  (NM),
    .INIT_CLR      (IC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_intr_src   (src),
    .i_msk        (msk),
    .i_clr_vld    (clr_vld),
    .i_clr        (clr),
    .i_init_clr   (init_clr),
    .i_trig_type  (trig_type),
    .i_pulse_width(pw),
    .o_raw_stat   (raw_stat),
    .o_intr_stat  (intr_stat),
    .o_intr       (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw = '0; m_prev = '0; m_type = 1'b0; m_intr = 1'b0;
    m_active = 1'b0; m_gap = 1'b0; m_pend = 1'b0; m_left = 0;
  endtask

  // One clock of the behavioural model, using the inputs as currently driven.
  task automatic model_step();
    logic [1:0] stat, ceff;
    logic       trg;
    int         wid;
    stat = m_raw & (~msk | NM);
    trg  = |(stat & ~m_prev);
    wid  = (pw == 0) ? 1 : int'(pw);
    ceff = (clr_vld ? clr : 2'b00) | (init_clr ? IC : 2'b00);
    if (trig_type != m_type) begin
      m_active = 1'b0; m_gap = 1'b0; m_pend = 1'b0; m_left = 0;
      m_intr = trig_type ? 1'b0 : |stat;
    end else if (!trig_type) begin
      m_intr = |stat;
    end else begin
      if (m_active) begin
        if (trg) m_pend = 1'b1;
        if (m_left == 0) begin
          m_active = 1'b0;
          m_gap    = 1'b1;
        end else begin
          m_left--;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
        if (m_pend || trg) begin
          m_pend   = 1'b0;
          m_active = 1'b1;
          m_left   = wid - 1;
        end
      end else if (trg) begin
        m_active = 1'b1;
        m_left   = wid - 1;
      end
      m_intr = m_active;
    end
    m_raw  = src | (m_raw & ~ceff);
    m_prev = stat;
    m_type = trig_type;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("raw", 32'(raw_stat), 32'(m_raw));
    chk("stat", 32'(intr_stat), 32'(m_raw & (~msk | NM)));
    chk("intr", 32'(intr), 32'(m_intr));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    src = '0; msk = '0; clr = '0; clr_vld = 1'b0; init_clr = 1'b0;
    trig_type = 1'b0; pw = 8'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_raw", 32'(raw_stat), 0);
    chk("rst_stat", 32'(intr_stat), 0);
    chk("rst_intr", 32'(intr), 0);
    rst_n = 1'b1;
    tick();

    // Level assert and W1C clear
    src = 2'b10; tick();
    chk("lvl_raw_t1", 32'(raw_stat), 32'h2);
    src = 2'b00; tick();
    chk("lvl_intr_t2", 32'(intr), 1);
    clr_vld = 1'b1; clr = 2'b10; tick();
    chk("lvl_clr_raw", 32'(raw_stat), 0);
    clr_vld = 1'b0; tick();
    chk("lvl_clr_intr", 32'(intr), 0);

    // Mask versus non-maskable, then init-clear
    msk = 2'b11; src = 2'b11; tick();
    chk("msk_raw", 32'(raw_stat), 32'h3);
    chk("msk_stat", 32'(intr_stat), 32'h1);
    src = 2'b00; tick();
    chk("msk_intr", 32'(intr), 1);
    init_clr = 1'b1; tick();
    chk("iclr_raw", 32'(raw_stat), 32'h2);
    init_clr = 1'b0; tick();
    chk("iclr_intr", 32'(intr), 0);

    // Set and clear in the same cycle
    msk = 2'b00; src = 2'b10; clr_vld = 1'b1; clr = 2'b10; tick();
    chk("collide_raw", 32'(raw_stat), 32'h2);
    src = 2'b00; tick();
    clr_vld = 1'b0; tick(); tick();

    // Pulse width 10
    trig_type = 1'b1; tick(); tick(); tick();
    pw = 8'd10; src = 2'b10; tick();
    chk("p10_t1", 32'(intr), 0);
    src = 2'b00;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("p10_shape", 32'(intr), 32'(k < 10));
    end
    clr_vld = 1'b1; clr = 2'b11; tick();
    clr_vld = 1'b0; tick(); tick();

    // Pulse width 0 behaves as 1
    pw = 8'd0; src = 2'b10; tick();
    chk("p0_t1", 32'(intr), 0);
    src = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p0_shape", 32'(intr), 32'(k == 0));
    end
    clr_vld = 1'b1; clr = 2'b11; tick();
    clr_vld = 1'b0; tick(); tick();

    // Pending retrigger: 4 high, 1 low, 4 high
    pw = 8'd4; src = 2'b10; tick();
    src = 2'b00;
    for (int c = 2; c < 12; c++) begin
      tick();
      chk("pend_shape", 32'(intr), 32'((c >= 2 && c <= 5) || (c >= 7 && c <= 10)));
      src = (c == 3) ? 2'b01 : 2'b00;
    end
    src = 2'b00; clr_vld = 1'b1; clr = 2'b11; tick();
    clr_vld = 1'b0; tick(); tick();

    // Unmasking a pending bit triggers one pulse
    msk = 2'b10; src = 2'b10; tick();
    src = 2'b00; tick(); tick();
    chk("unmsk_before", 32'(intr), 0);
    msk = 2'b00;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("unmsk_shape", 32'(intr), 32'(k < 4));
    end

    // Mode change mid-pulse with status pending
    pw = 8'd10; src = 2'b01; tick();
    src = 2'b00; tick(); tick();
    chk("chg_inpulse", 32'(intr), 1);
    trig_type = 1'b0; tick();
    chk("chg_level", 32'(intr), 1);
    clr_vld = 1'b1; clr = 2'b11; tick();
    clr_vld = 1'b0; tick();
    chk("chg_level_clr", 32'(intr), 0);

    // Asynchronous reset mid-pulse
    trig_type = 1'b1; tick();
    src = 2'b10; tick();
    src = 2'b00; tick(); tick();
    chk("rstmid_pre", 32'(intr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_intr", 32'(intr), 0);
    chk("rstmid_raw", 32'(raw_stat), 0);
    chk("rstmid_stat", 32'(intr_stat), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      src      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      clr_vld  = ($urandom_range(0, 4) == 0);
      clr      = 2'($urandom_range(0, 3));
      init_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) msk = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) trig_type = ~trig_type;
      if ($urandom_range(0, 14) == 0) pw = 8'($urandom_range(0, 6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
